// File: rtl/mc_pkg.sv
// Shared types for the multi-cycle MIPS control FSM: states, opcodes, mux encodings and the control word.
// The optional bne support is selected with the MC_BNE_EN macro (see mc_controller).
package mc_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMRD,
        S_MEMWB,
        S_MEMWR,
        S_EXEC,
        S_ALUWB,
        S_ADDIEX,
        S_ADDIWB,
        S_BRANCH,
        S_JUMP
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;

    localparam logic [1:0] ALUSRCB_REGB  = 2'b00;
    localparam logic [1:0] ALUSRCB_FOUR  = 2'b01;
    localparam logic [1:0] ALUSRCB_IMM   = 2'b10;
    localparam logic [1:0] ALUSRCB_IMMSH = 2'b11;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic       pcwrite;
        logic       branch;
        logic       iord;
        logic       memwrite;
        logic       irwrite;
        logic       regwrite;
        logic       regdst;
        logic       memtoreg;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] aluop;
        logic [1:0] pcsrc;
    } ctrl_t;

    // States whose exit completes an instruction.
    function automatic logic retires(state_t s);
        return (s == S_MEMWB) || (s == S_MEMWR) || (s == S_ALUWB) ||
               (s == S_ADDIWB) || (s == S_BRANCH) || (s == S_JUMP);
    endfunction

endpackage

// File: rtl/mc_outdec.sv
// Moore output decoder: maps the current FSM state to its control word.
// Anything a state does not mention stays at zero.
module mc_outdec
    import mc_pkg::*;
(
    input  state_t state_i,
    output ctrl_t  ctrl_o
);

    always_comb begin
        ctrl_o = '0;
        case (state_i)
            S_FETCH: begin
                ctrl_o.alusrcb = ALUSRCB_FOUR;
                ctrl_o.aluop   = ALUOP_ADD;
                ctrl_o.pcsrc   = PCSRC_ALU;
                ctrl_o.irwrite = 1'b1;
                ctrl_o.pcwrite = 1'b1;
            end
            // Branch target is precomputed here so BRANCH only needs the compare.
            S_DECODE: begin
                ctrl_o.alusrcb = ALUSRCB_IMMSH;
                ctrl_o.aluop   = ALUOP_ADD;
            end
            S_MEMADR, S_ADDIEX: begin
                ctrl_o.alusrca = 1'b1;
                ctrl_o.alusrcb = ALUSRCB_IMM;
                ctrl_o.aluop   = ALUOP_ADD;
            end
            S_MEMRD: ctrl_o.iord = 1'b1;
            S_MEMWB: begin
                ctrl_o.memtoreg = 1'b1;
                ctrl_o.regwrite = 1'b1;
            end
            S_MEMWR: begin
                ctrl_o.iord     = 1'b1;
                ctrl_o.memwrite = 1'b1;
            end
            S_EXEC: begin
                ctrl_o.alusrca = 1'b1;
                ctrl_o.alusrcb = ALUSRCB_REGB;
                ctrl_o.aluop   = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                ctrl_o.regdst   = 1'b1;
                ctrl_o.regwrite = 1'b1;
            end
            S_ADDIWB: ctrl_o.regwrite = 1'b1;
            S_BRANCH: begin
                ctrl_o.alusrca = 1'b1;
                ctrl_o.alusrcb = ALUSRCB_REGB;
                ctrl_o.aluop   = ALUOP_SUB;
                ctrl_o.pcsrc   = PCSRC_ALUOUT;
                ctrl_o.branch  = 1'b1;
            end
            S_JUMP: begin
                ctrl_o.pcsrc   = PCSRC_JUMP;
                ctrl_o.pcwrite = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mc_controller.sv
// Main control FSM of the multi-cycle MIPS core, plus the retired-instruction counter.
// Define MC_BNE_EN to decode op 6'h05 as bne; otherwise it is reported as illegal.
module mc_controller
    import mc_pkg::*;
#(
    parameter int RETIRE_W = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [5:0]          op,
    input  logic                zero,
    output logic                pcen,
    output logic                iord,
    output logic                memwrite,
    output logic                irwrite,
    output logic                regwrite,
    output logic                regdst,
    output logic                memtoreg,
    output logic                alusrca,
    output logic [1:0]          alusrcb,
    output logic [1:0]          aluop,
    output logic [1:0]          pcsrc,
    output logic                illegal,
    output logic [RETIRE_W-1:0] instret
);

    state_t                state_q, state_d;
    logic [RETIRE_W-1:0]   instret_q, instret_d;
    logic                  bne_q, bne_d;
    logic                  illegalDec;
    ctrl_t                 ctrl;

    mc_outdec u_outdec (
        .state_i (state_q),
        .ctrl_o  (ctrl)
    );

    always_comb begin
        state_d    = state_q;
        bne_d      = bne_q;
        illegalDec = 1'b0;
        instret_d  = instret_q;
        case (state_q)
            S_FETCH: state_d = S_DECODE;
            S_DECODE: begin
                bne_d = 1'b0;
                case (op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXEC;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_J:         state_d = S_JUMP;
`ifdef MC_BNE_EN
                    OP_BNE: begin
                        state_d = S_BRANCH;
                        bne_d   = 1'b1;
                    end
`endif
                    default: begin
                        state_d    = S_FETCH;
                        illegalDec = 1'b1;
                    end
                endcase
            end
            S_MEMADR: state_d = (op == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:  state_d = S_MEMWB;
            S_EXEC:   state_d = S_ALUWB;
            S_ADDIEX: state_d = S_ADDIWB;
            default:  state_d = S_FETCH;
        endcase
        if (retires(state_q)) begin
            instret_d = instret_q + RETIRE_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_FETCH;
            instret_q <= '0;
            bne_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            instret_q <= instret_d;
            bne_q     <= bne_d;
        end
    end

    // Strobes are forced low during reset; the muxes simply show the FETCH settings.
    assign pcen     = ~reset & (ctrl.pcwrite | (ctrl.branch & (zero ^ bne_q)));
    assign memwrite = ~reset & ctrl.memwrite;
    assign irwrite  = ~reset & ctrl.irwrite;
    assign regwrite = ~reset & ctrl.regwrite;
    assign iord     = ctrl.iord;
    assign regdst   = ctrl.regdst;
    assign memtoreg = ctrl.memtoreg;
    assign alusrca  = ctrl.alusrca;
    assign alusrcb  = ctrl.alusrcb;
    assign aluop    = ctrl.aluop;
    assign pcsrc    = ctrl.pcsrc;
    assign illegal  = illegalDec;
    assign instret  = instret_q;

endmodule
